// File: rtl/byte_serializer_if.sv
// FIFO-head handshake between the 8-entry byte FIFO and the serializer that drains it.
// The FIFO side presents the head byte and its empty flag; the consumer returns a pop pulse.
interface byte_serializer_if;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_dequeue;

    modport master (
        output fifo_data,
        output fifo_empty,
        input  fifo_dequeue
    );

    modport slave (
        input  fifo_data,
        input  fifo_empty,
        output fifo_dequeue
    );
endinterface

// File: rtl/byte_serializer.sv
// Pops bytes from the FIFO head and shifts each out MSB first, one bit per BIT_CYCLES clocks,
// followed by an optional idle gap; counts the bytes that went out in full.
module byte_serializer #(
    parameter int BIT_CYCLES = 10,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    byte_serializer_if.slave     fifo,
    output logic                 serial_out,
    output logic                 frame_valid,
    output logic                 byte_done,
    output logic                 busy,
    output logic [CNT_W-1:0]     byte_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    // Timers keep at least one bit so the degenerate 1-cycle settings still elaborate.
    localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(BIT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]    state;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_idx;
    logic [TW-1:0] bit_timer;
    logic [GW-1:0] gap_timer;
    logic          dequeue;

    // NOTE: every register here is updated with <= so all of them see the pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= 8'h00;
            bit_idx    <= 3'd0;
            bit_timer  <= '0;
            gap_timer  <= '0;
            dequeue    <= 1'b0;
            byte_done  <= 1'b0;
            byte_count <= '0;
        end else begin
            dequeue   <= 1'b0;
            byte_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && !fifo.fifo_empty) begin
                        shift_reg <= fifo.fifo_data;
                        dequeue   <= 1'b1;
                        bit_idx   <= 3'd0;
                        bit_timer <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_timer == BIT_LAST) begin
                        bit_timer <= '0;
                        shift_reg <= {shift_reg[6:0], 1'b0};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            byte_done  <= 1'b1;
                            byte_count <= byte_count + CNT_W'(1);
                            gap_timer  <= '0;
                            state      <= (GAP_CYCLES == 0) ? IDLE : GAP;
                        end
                    end else begin
                        bit_timer <= bit_timer + TW'(1);
                    end
                end
                GAP: begin
                    if (gap_timer == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_timer <= gap_timer + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The captured MSB is on the line in the same cycle the pop pulse is seen by the FIFO.
    assign fifo.fifo_dequeue = dequeue;
    assign busy              = (state != IDLE);
    assign frame_valid       = (state == SHIFT);
    assign serial_out        = frame_valid & shift_reg[7];

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: default instance plus a BIT_CYCLES=1 / GAP_CYCLES=0 /
// CNT_W=3 instance; outputs are logged on the falling edge and decoded against expected bytes.
module tb_byte_serializer;

    localparam int FV = 0, SO = 1, DQ = 2, BD = 3, BS = 4, CN = 5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_a, en_a, so_a, fv_a, bd_a, busy_a;
    logic [15:0] cnt_a;
    logic       reset_b, en_b, so_b, fv_b, bd_b, busy_b;
    logic [2:0] cnt_b;

    byte_serializer_if if_a ();
    byte_serializer_if if_b ();

    byte_serializer dut_a (
        .clock(clock), .reset(reset_a), .enable(en_a), .fifo(if_a),
        .serial_out(so_a), .frame_valid(fv_a), .byte_done(bd_a),
        .busy(busy_a), .byte_count(cnt_a)
    );

    byte_serializer #(.BIT_CYCLES(1), .GAP_CYCLES(0), .CNT_W(3)) dut_b (
        .clock(clock), .reset(reset_b), .enable(en_b), .fifo(if_b),
        .serial_out(so_b), .frame_valid(fv_b), .byte_done(bd_b),
        .busy(busy_b), .byte_count(cnt_b)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int fv_q[$], so_q[$], dq_q[$], bd_q[$], bs_q[$], cn_q[$];

    task automatic sync_fifo();
        if_a.fifo_empty = (q_a.size() == 0);
        if_a.fifo_data  = (q_a.size() > 0) ? q_a[0] : 8'h00;
        if_b.fifo_empty = (q_b.size() == 0);
        if_b.fifo_data  = (q_b.size() > 0) ? q_b[0] : 8'h00;
    endtask

    task automatic clear_log();
        fv_q.delete(); so_q.delete(); dq_q.delete();
        bd_q.delete(); bs_q.delete(); cn_q.delete();
    endtask

    // Samples one DUT per falling edge and pops the FIFO model when a dequeue pulse is seen.
    task automatic record(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (sel == 0) begin
                fv_q.push_back(int'(fv_a)); so_q.push_back(int'(so_a));
                dq_q.push_back(int'(if_a.fifo_dequeue)); bd_q.push_back(int'(bd_a));
                bs_q.push_back(int'(busy_a)); cn_q.push_back(int'(cnt_a));
                if (if_a.fifo_dequeue === 1'b1 && q_a.size() > 0) void'(q_a.pop_front());
            end else begin
                fv_q.push_back(int'(fv_b)); so_q.push_back(int'(so_b));
                dq_q.push_back(int'(if_b.fifo_dequeue)); bd_q.push_back(int'(bd_b));
                bs_q.push_back(int'(busy_b)); cn_q.push_back(int'(cnt_b));
                if (if_b.fifo_dequeue === 1'b1 && q_b.size() > 0) void'(q_b.pop_front());
            end
            sync_fifo();
        end
    endtask

    task automatic apply_reset(input int sel);
        if (sel == 0) begin reset_a = 1'b1; en_a = 1'b0; q_a.delete(); end
        else          begin reset_b = 1'b1; en_b = 1'b0; q_b.delete(); end
        sync_fifo();
        repeat (2) @(negedge clock);
        if (sel == 0) reset_a = 1'b0; else reset_b = 1'b0;
        clear_log();
    endtask

    function automatic int get(input int which, input int idx);
        if (idx < 0 || idx >= fv_q.size()) return -1;
        case (which)
            FV:      return fv_q[idx];
            SO:      return so_q[idx];
            DQ:      return dq_q[idx];
            BD:      return bd_q[idx];
            BS:      return bs_q[idx];
            default: return cn_q[idx];
        endcase
    endfunction

    function automatic int count_of(input int which);
        int c = 0;
        for (int i = 0; i < fv_q.size(); i++) if (get(which, i) == 1) c++;
        return c;
    endfunction

    function automatic int nth_of(input int which, input int n);
        int c = 0;
        for (int i = 0; i < fv_q.size(); i++) begin
            if (get(which, i) == 1) begin
                if (c == n) return i;
                c++;
            end
        end
        return -1;
    endfunction

    function automatic logic [7:0] decode(input int s, input int bc);
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 8; i++) v = {v[6:0], get(SO, s + i * bc) == 1};
        return v;
    endfunction

    function automatic bit held_ok(input int s, input int bc);
        for (int i = 0; i < 8; i++)
            for (int t = 0; t < bc; t++) begin
                if (get(FV, s + i * bc + t) != 1) return 1'b0;
                if (get(SO, s + i * bc + t) != get(SO, s + i * bc)) return 1'b0;
            end
        return 1'b1;
    endfunction

    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
        q_a.push_back(8'hFF); q_b.push_back(8'hFF);
        sync_fifo();
        repeat (3) @(negedge clock);
        total++;
        if ({if_a.fifo_dequeue, so_a, fv_a, bd_a, busy_a} !== 5'b0) begin
            bad++; $display("FAIL reset_outputs_a: got %b expected 00000",
                            {if_a.fifo_dequeue, so_a, fv_a, bd_a, busy_a});
        end
        total++;
        if (cnt_a !== 16'd0) begin
            bad++; $display("FAIL reset_count_a: got %0d expected 0", cnt_a);
        end
        total++;
        if ({if_b.fifo_dequeue, so_b, fv_b, bd_b, busy_b, cnt_b} !== 8'b0) begin
            bad++; $display("FAIL reset_outputs_b: got %b expected 00000000",
                            {if_b.fifo_dequeue, so_b, fv_b, bd_b, busy_b, cnt_b});
        end
    endtask

    task automatic test_idle_empty();
        apply_reset(0);
        en_a = 1'b1;
        record(0, 200);
        total++;
        if (count_of(DQ) !== 0) begin
            bad++; $display("FAIL empty_dequeue: got %0d pulses expected 0", count_of(DQ));
        end
        total++;
        if (count_of(BS) + count_of(SO) !== 0) begin
            bad++; $display("FAIL empty_busy_serial: got %0d high cycles expected 0",
                            count_of(BS) + count_of(SO));
        end
        total++;
        if (cnt_a !== 16'd0) begin
            bad++; $display("FAIL empty_count: got %0d expected 0", cnt_a);
        end
    endtask

    task automatic test_single();
        apply_reset(0);
        q_a.push_back(8'hAA); sync_fifo();
        en_a = 1'b1;
        record(0, 120);
        total++;
        if (count_of(DQ) !== 1 || nth_of(DQ, 0) !== 0) begin
            bad++; $display("FAIL single_dequeue: got %0d pulses at %0d expected 1 at 0",
                            count_of(DQ), nth_of(DQ, 0));
        end
        total++;
        if (so_q[0] !== 1 || fv_q[0] !== 1) begin
            bad++; $display("FAIL single_first_bit: got so=%0d fv=%0d expected 1 1", so_q[0], fv_q[0]);
        end
        total++;
        if (count_of(FV) !== 80) begin
            bad++; $display("FAIL single_fv_cycles: got %0d expected 80", count_of(FV));
        end
        total++;
        if (decode(0, 10) !== 8'hAA || !held_ok(0, 10)) begin
            bad++; $display("FAIL single_data: got %h held=%0d expected aa held=1",
                            decode(0, 10), held_ok(0, 10));
        end
        total++;
        if (count_of(BD) !== 1 || nth_of(BD, 0) !== 80) begin
            bad++; $display("FAIL single_byte_done: got %0d pulses at %0d expected 1 at 80",
                            count_of(BD), nth_of(BD, 0));
        end
        total++;
        if ({bs_q[80], bs_q[81], bs_q[82], fv_q[80], so_q[80]} !== {1, 1, 0, 0, 0}) begin
            bad++; $display("FAIL single_gap: got busy=%0d%0d%0d fv=%0d so=%0d expected busy=110 fv=0 so=0",
                            bs_q[80], bs_q[81], bs_q[82], fv_q[80], so_q[80]);
        end
        total++;
        if (cnt_a !== 16'd1) begin
            bad++; $display("FAIL single_count: got %0d expected 1", cnt_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[4] = '{8'hCC, 8'hF0, 8'h0F, 8'hFF};
        apply_reset(0);
        for (int k = 0; k < 4; k++) q_a.push_back(exp[k]);
        sync_fifo();
        en_a = 1'b1;
        record(0, 4 * 83 + 20);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (nth_of(DQ, k) !== 83 * k) begin
                bad++; $display("FAIL b2b_start%0d: got %0d expected %0d", k, nth_of(DQ, k), 83 * k);
            end
            total++;
            if (decode(83 * k, 10) !== exp[k] || !held_ok(83 * k, 10)) begin
                bad++; $display("FAIL b2b_data%0d: got %h held=%0d expected %h held=1",
                                k, decode(83 * k, 10), held_ok(83 * k, 10), exp[k]);
            end
        end
        total++;
        if (count_of(DQ) !== 4 || cnt_a !== 16'd4) begin
            bad++; $display("FAIL b2b_count: got %0d pulses count=%0d expected 4 count=4",
                            count_of(DQ), cnt_a);
        end
        total++;
        if (busy_a !== 1'b0) begin
            bad++; $display("FAIL b2b_idle: got busy=%0d expected 0", busy_a);
        end
    endtask

    task automatic test_enable_drop();
        int l;
        apply_reset(0);
        q_a.push_back(8'h33); q_a.push_back(8'h3C); sync_fifo();
        en_a = 1'b1;
        record(0, 15);
        en_a = 1'b0;
        record(0, 200);
        total++;
        if (decode(0, 10) !== 8'h33 || !held_ok(0, 10) || nth_of(BD, 0) !== 80) begin
            bad++; $display("FAIL drop_complete: got %h done_at=%0d expected 33 done_at=80",
                            decode(0, 10), nth_of(BD, 0));
        end
        total++;
        if (count_of(DQ) !== 1 || cnt_a !== 16'd1 || busy_a !== 1'b0) begin
            bad++; $display("FAIL drop_hold: got pulses=%0d count=%0d busy=%0d expected 1 1 0",
                            count_of(DQ), cnt_a, busy_a);
        end
        l = fv_q.size();
        en_a = 1'b1;
        record(0, 100);
        total++;
        if (get(DQ, l) !== 1 || decode(l, 10) !== 8'h3C || cnt_a !== 16'd2) begin
            bad++; $display("FAIL drop_resume: got dq=%0d data=%h count=%0d expected 1 3c 2",
                            get(DQ, l), decode(l, 10), cnt_a);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(0);
        q_a.push_back(8'h55); q_a.push_back(8'h5A); sync_fifo();
        en_a = 1'b1;
        record(0, 40);
        reset_a = 1'b1;
        record(0, 1);
        total++;
        if ({dq_q[40], so_q[40], fv_q[40], bd_q[40], bs_q[40], cn_q[40]} !== {0, 0, 0, 0, 0, 0}) begin
            bad++; $display("FAIL midreset_outputs: got dq=%0d so=%0d fv=%0d bd=%0d busy=%0d cnt=%0d expected all 0",
                            dq_q[40], so_q[40], fv_q[40], bd_q[40], bs_q[40], cn_q[40]);
        end
        reset_a = 1'b0;
        record(0, 100);
        total++;
        if (get(DQ, 41) !== 1 || decode(41, 10) !== 8'h5A || !held_ok(41, 10)) begin
            bad++; $display("FAIL midreset_restart: got dq=%0d data=%h expected 1 5a",
                            get(DQ, 41), decode(41, 10));
        end
        total++;
        if (cnt_a !== 16'd1) begin
            bad++; $display("FAIL midreset_count: got %0d expected 1", cnt_a);
        end
    endtask

    task automatic test_wrap();
        int exp_cnt[3] = '{7, 0, 1};
        apply_reset(1);
        for (int k = 0; k < 9; k++) q_b.push_back(8'h99);
        sync_fifo();
        en_b = 1'b1;
        record(1, 90);
        for (int k = 0; k < 9; k++) begin
            total++;
            if (nth_of(DQ, k) !== 9 * k || decode(9 * k, 1) !== 8'h99 || !held_ok(9 * k, 1)) begin
                bad++; $display("FAIL wrap_byte%0d: got start=%0d data=%h expected start=%0d data=99",
                                k, nth_of(DQ, k), decode(9 * k, 1), 9 * k);
            end
        end
        for (int k = 6; k < 9; k++) begin
            total++;
            if (get(BD, 9 * k + 8) !== 1 || get(CN, 9 * k + 8) !== exp_cnt[k - 6]) begin
                bad++; $display("FAIL wrap_count%0d: got done=%0d cnt=%0d expected done=1 cnt=%0d",
                                k, get(BD, 9 * k + 8), get(CN, 9 * k + 8), exp_cnt[k - 6]);
            end
        end
        total++;
        if (count_of(FV) !== 72 || cnt_b !== 3'd1) begin
            bad++; $display("FAIL wrap_total: got fv=%0d cnt=%0d expected fv=72 cnt=1",
                            count_of(FV), cnt_b);
        end
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
        sync_fifo();
        test_reset();
        test_idle_empty();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
- Downstream consumer of the 8-entry byte FIFO.
- Pops one byte at a time from the FIFO head and shifts it out serially, MSB first, one bit per BIT_CYCLES clocks, with a frame-valid strobe.
- Mirrors the serial input path: the deserializer feeds the FIFO; this block drains it to a serial line.
- Optional inter-byte gap; counts transmitted bytes.

Parameters:
- BIT_CYCLES, 10, clock cycles each bit is held on serial_out (must be >= 1).
- GAP_CYCLES, 2, idle cycles between consecutive bytes (0 allowed: no gap).
- CNT_W, 16, width of the transmitted-byte counter.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  permits starting a new byte; sampled only in IDLE.
- fifo_data  input  8  FIFO head byte, valid whenever fifo_empty=0.
- fifo_empty  input  1  FIFO status, 1 = no byte available.
- fifo_dequeue  output  1  one-cycle pop pulse to the FIFO.
- serial_out  output  1  serial data, MSB first.
- frame_valid  output  1  high while serial_out carries a data bit.
- byte_done  output  1  one-cycle pulse after the last bit of a byte.
- busy  output  1  high in any state other than IDLE.
- byte_count  output  CNT_W  bytes fully transmitted since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - State goes to IDLE.
  - fifo_dequeue, serial_out, frame_valid, byte_done and busy all go to 0.
  - byte_count goes to 0; shift register and counters clear.
  - Reset overrides all other inputs.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - If enable=1 and fifo_empty=0 at edge N:
    - Capture fifo_data into the shift register.
    - Drive fifo_dequeue=1 for exactly the cycle following edge N.
    - Go to SHIFT with bit_idx=0 and bit_timer=0.
  - Otherwise stay in IDLE. fifo_dequeue is never asserted while fifo_empty=1.
- SHIFT:
  - serial_out = shift_reg[7]; frame_valid=1; busy=1.
  - bit_timer counts 0..BIT_CYCLES-1. At terminal count, shift left by 1, increment bit_idx, reset bit_timer.
  - After bit 7's terminal count:
    - byte_done=1 for one cycle and byte_count increments.
    - Go to GAP, or directly to IDLE if GAP_CYCLES=0.
- GAP:
  - serial_out=0, frame_valid=0, busy=1 for GAP_CYCLES cycles, then IDLE.
- Latency and throughput:
  - Bit 7 appears on serial_out in the same cycle fifo_dequeue is high.
  - Each byte occupies exactly 8*BIT_CYCLES cycles with frame_valid=1.
  - Byte-to-byte period with a continuously non-empty FIFO is 8*BIT_CYCLES + GAP_CYCLES + 1 cycles (the +1 is the IDLE decision cycle).
- Boundary conditions:
  - **enable dropped mid-byte:** the current byte completes and the gap still runs. No new byte starts until enable=1.
  - **fifo_empty rising mid-byte:** no effect on the byte in flight. The block simply stays in IDLE afterwards.
  - **fifo_data changing after capture:** ignored; only the captured copy is shifted.
  - **Reset mid-byte:** the byte is abandoned. It is not re-fetched, since it was already popped, and byte_count does not increment.
  - **byte_count wrap:** 2^CNT_W-1 rolls over to 0 without any flag.
  - **BIT_CYCLES=1:** one bit per clock; the FSM must not skip or repeat bits.

Test Plan:
- Reset, then fifo_empty=1 with enable=1 for 200 cycles -> fifo_dequeue never asserted; busy=0, serial_out=0, byte_count=0.
- FIFO holds 0xAA, enable=1, defaults -> single fifo_dequeue pulse; serial_out 1,0,1,0,1,0,1,0, each held 10 cycles with frame_valid=1; byte_done once; byte_count=1.
- FIFO holds 0xCC, 0xF0, 0x0F, 0xFF, kept non-empty -> four bytes back to back, 83-cycle period; bit streams match MSB first; byte_count=4; then IDLE with busy=0.
- enable dropped 15 cycles into 0x33 -> 0x33 fully transmitted; no further dequeue while enable=0; resumes on the next byte once enable=1.
- reset asserted 40 cycles into 0x55 -> next cycle all outputs 0; byte_count unchanged from before (0 if first); next byte starts cleanly from bit 7.
- BIT_CYCLES=1, GAP_CYCLES=0, CNT_W=3, 9 bytes 0x99 -> 1 bit per cycle, 9-cycle period; byte_count wraps 7->0->1.
